// File: rtl/dot_gpio_axil_slave.sv
// dot_gpio_axil_slave
// AXI4-Lite responder for the DotPainter GPIO block. Holds OUT, DIR,
// IRQ_MASK and SCRATCH, samples the pins through a 2-flop synchronizer and
// latches rising edges into a write-1-to-clear IRQ_STATUS register.
//
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*              write address / data / response channels
//   S_AXI_AR*/R*                 read address / data channels
//   S_AXI_AWPROT, S_AXI_ARPROT   accepted, not used
//   gpio_i                       asynchronous pin inputs
//   gpio_o, gpio_oe              OUT register value, DIR register value (1 = drive)
//   irq                          registered |(IRQ_STATUS & IRQ_MASK)
module dot_gpio_axil_slave #(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [4:0]            S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [4:0]            S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] IDX_OUT     = 3'd0;
    localparam logic [2:0] IDX_DIR     = 3'd1;
    localparam logic [2:0] IDX_MASK    = 3'd2;
    localparam logic [2:0] IDX_SCRATCH = 3'd3;
    localparam logic [2:0] IDX_IN      = 3'd4;
    localparam logic [2:0] IDX_STATUS  = 3'd5;

    // Byte-lane merge of new data over an old word under a write strobe.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Zero-extend a GPIO-wide value to the 32-bit bus.
    function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    logic                  ready_en_r;
    logic                  aw_full_r;
    logic [2:0]            aw_idx_r;
    logic                  w_full_r;
    logic [31:0]           w_data_r;
    logic [3:0]            w_strb_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic [1:0]            rresp_r;
    logic [GPIO_WIDTH-1:0] out_r, dir_r, mask_r, sync1_r, sync2_r, prev_r, status_r;
    logic [31:0]           scratch_r;
    logic                  irq_r;

    logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [31:0]           wr_old_s, wr_new_s, rd_data_s;
    logic [1:0]            rd_resp_s;
    logic [GPIO_WIDTH-1:0] clear_mask_s, rise_s;
    logic                  unused_s;

    // Address LSBs and protection bits have no function here.
    assign unused_s = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

    // ready_en_r keeps all READYs low while reset is held.
    assign S_AXI_AWREADY = ready_en_r & ~aw_full_r;
    assign S_AXI_WREADY  = ready_en_r & ~w_full_r;
    assign S_AXI_ARREADY = ready_en_r & ~rvalid_r;

    assign aw_hs_s  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs_s   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs_s  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit_s = aw_full_r & w_full_r & ~bvalid_r;
    assign rise_s   = sync2_r & ~prev_r;

    // Select the current value of the write target and the W1C clear mask.
    always_comb begin
        wr_old_s     = 32'd0;
        clear_mask_s = '0;
        case (aw_idx_r)
            IDX_OUT:     wr_old_s = zext(out_r);
            IDX_DIR:     wr_old_s = zext(dir_r);
            IDX_MASK:    wr_old_s = zext(mask_r);
            IDX_SCRATCH: wr_old_s = scratch_r;
            default:     wr_old_s = 32'd0;
        endcase
        wr_new_s = merge_strb(wr_old_s, w_data_r, w_strb_r);
        if (commit_s && (aw_idx_r == IDX_STATUS)) begin
            clear_mask_s = merge_strb(32'd0, w_data_r, w_strb_r) & zext({GPIO_WIDTH{1'b1}});
        end else begin
            clear_mask_s = '0;
        end
    end

    // Read data mux; unmapped words read zero with SLVERR.
    always_comb begin
        rd_data_s = 32'd0;
        rd_resp_s = RESP_OKAY;
        case (S_AXI_ARADDR[4:2])
            IDX_OUT:     rd_data_s = zext(out_r);
            IDX_DIR:     rd_data_s = zext(dir_r);
            IDX_MASK:    rd_data_s = zext(mask_r);
            IDX_SCRATCH: rd_data_s = scratch_r;
            IDX_IN:      rd_data_s = zext(sync2_r);
            IDX_STATUS:  rd_data_s = zext(status_r);
            default: begin
                rd_data_s = 32'd0;
                rd_resp_s = RESP_SLVERR;
            end
        endcase
    end

    // READY enable: low in reset, high from the first edge after release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) ready_en_r <= 1'b0;
        else        ready_en_r <= 1'b1;
    end

    // Write address holding buffer.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full_r <= 1'b0;
            aw_idx_r  <= 3'd0;
        end else if (aw_hs_s) begin
            aw_full_r <= 1'b1;
            aw_idx_r  <= S_AXI_AWADDR[4:2];
        end else if (commit_s) begin
            aw_full_r <= 1'b0;
        end
    end

    // Write data holding buffer.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_full_r <= 1'b0;
            w_data_r <= 32'd0;
            w_strb_r <= 4'd0;
        end else if (w_hs_s) begin
            w_full_r <= 1'b1;
            w_data_r <= S_AXI_WDATA;
            w_strb_r <= S_AXI_WSTRB;
        end else if (commit_s) begin
            w_full_r <= 1'b0;
        end
    end

    // Write response: raised on commit, held until BREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= (aw_idx_r > IDX_STATUS) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_r && S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
        end
    end

    // Read-write registers, updated on the commit edge only.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            out_r     <= '0;
            dir_r     <= '0;
            mask_r    <= '0;
            scratch_r <= 32'd0;
        end else if (commit_s) begin
            case (aw_idx_r)
                IDX_OUT:     out_r     <= wr_new_s[GPIO_WIDTH-1:0];
                IDX_DIR:     dir_r     <= wr_new_s[GPIO_WIDTH-1:0];
                IDX_MASK:    mask_r    <= wr_new_s[GPIO_WIDTH-1:0];
                IDX_SCRATCH: scratch_r <= wr_new_s;
                default:     scratch_r <= scratch_r;
            endcase
        end
    end

    // Read channel: capture on AR handshake, hold until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_resp_s;
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
        end
    end

    // Pin synchronizer plus previous-value flop for edge detection.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= gpio_i;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Interrupt status: a new rising edge wins over a simultaneous clear.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            status_r <= '0;
            irq_r    <= 1'b0;
        end else begin
            status_r <= (status_r & ~clear_mask_s[GPIO_WIDTH-1:0]) | rise_s;
            irq_r    <= |(status_r & mask_r);
        end
    end

    assign S_AXI_BVALID = bvalid_r;
    assign S_AXI_BRESP  = bresp_r;
    assign S_AXI_RVALID = rvalid_r;
    assign S_AXI_RDATA  = rdata_r;
    assign S_AXI_RRESP  = rresp_r;
    assign gpio_o       = out_r;
    assign gpio_oe      = dir_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_dot_gpio_axil_slave.sv
module tb_dot_gpio_axil_slave;

    logic        clk;
    logic        rst;
    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq;

    int total_cnt = 0;
    int pass_cnt  = 0;

    dot_gpio_axil_slave #(.GPIO_WIDTH(32)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_go, w_go, got;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            step();
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
        end
        check("write_accepted", 32'(!(awvalid || wvalid)), 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        got = 1'b0; resp = 2'b11;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin
                resp = bresp;
                got  = 1'b1;
            end
            step();
        end
        check("bvalid_seen", 32'(got), 32'd1);
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        logic ar_go, got;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20 && arvalid; i++) begin
            ar_go = arready;
            step();
            if (ar_go) arvalid = 1'b0;
        end
        check("read_accepted", 32'(!arvalid), 32'd1);
        arvalid = 1'b0;
        got = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin
                data = rdata;
                resp = rresp;
                got  = 1'b1;
            end
            step();
        end
        check("rvalid_seen", 32'(got), 32'd1);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;

        vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00};
        vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
        vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0000_0003, 2'b00};
        vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0000_0004, 2'b00};
        vecs[4] = '{5'h18, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[5] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[6] = '{5'h10, 32'h0000_FFFF, 4'hF, 2'b00, 32'h0000_0000, 2'b00};

        rst = 1'b1;
        awaddr = 5'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0;
        bready = 1'b1; araddr = 5'd0; arvalid = 1'b0; rready = 1'b1; gpio_i = 32'd0;

        // Reset state
        step(); step();
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_gpio_o", gpio_o, 32'd0);
        check("rst_gpio_oe", gpio_oe, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_arready", 32'(arready), 32'd1);

        // Table: write then read back
        for (int i = 0; i < 7; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
            check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_bresp));
            axi_read(vecs[i].addr, data, resp);
            check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
            check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_rresp));
        end
        check("tbl_gpio_o", gpio_o, 32'h1);
        check("tbl_gpio_oe", gpio_oe, 32'h2);
        axi_read(5'h08, data, resp);
        check("mask_after_unmapped", data, 32'h3);
        axi_read(5'h0C, data, resp);
        check("scratch_after_unmapped", data, 32'h4);

        // Write latency: handshake at edge N, gpio_o/BVALID after N+1
        bready = 1'b0;
        awaddr = 5'h00; wdata = 32'h0000_005A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("lat_gpio_o_old", gpio_o, 32'h1);
        check("lat_bvalid_early", 32'(bvalid), 32'd0);
        step();
        check("lat_gpio_o_new", gpio_o, 32'h5A);
        check("lat_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        step();
        check("lat_bvalid_clr", 32'(bvalid), 32'd0);

        // W before AW, partial strobe, BVALID held under BREADY low
        axi_write(5'h0C, 32'd0, 4'hF, resp);
        bready = 1'b0;
        wdata = 32'hAABB_CCDD; wstrb = 4'b0010; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("w_buf_full_wready", 32'(wready), 32'd0);
        step(); step();
        awaddr = 5'h0C; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("w_first_bvalid_early", 32'(bvalid), 32'd0);
        step();
        check("w_first_bvalid", 32'(bvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("bhold%0d_bvalid", i), 32'(bvalid), 32'd1);
            check($sformatf("bhold%0d_bresp", i), 32'(bresp), 32'd0);
        end
        bready = 1'b1;
        step();
        check("bhold_release", 32'(bvalid), 32'd0);
        axi_read(5'h0C, data, resp);
        check("scratch_strb", data, 32'h0000_CC00);

        // Rising-edge interrupt
        axi_write(5'h08, 32'h1, 4'hF, resp);
        gpio_i = 32'h1;
        step(); step(); step();
        check("irq_not_yet", 32'(irq), 32'd0);
        step();
        check("irq_set", 32'(irq), 32'd1);
        axi_read(5'h10, data, resp);
        check("in_reg", data, 32'h1);
        axi_read(5'h14, data, resp);
        check("status_set", data, 32'h1);
        axi_write(5'h14, 32'h1, 4'hF, resp);
        check("w1c_bresp", 32'(resp), 32'd0);
        step();
        check("irq_cleared", 32'(irq), 32'd0);
        axi_read(5'h14, data, resp);
        check("status_cleared", data, 32'h0);

        // W1C commit coinciding with a new rising edge
        gpio_i = 32'h0;
        repeat (4) step();
        gpio_i = 32'h1;
        bready = 1'b0;
        step();
        awaddr = 5'h14; wdata = 32'h1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("coincide_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        step(); step();
        check("coincide_irq", 32'(irq), 32'd1);
        axi_read(5'h14, data, resp);
        check("coincide_status", data, 32'h1);

        // Read stall with ARVALID held high
        rready = 1'b0;
        araddr = 5'h00; arvalid = 1'b1;
        step();
        check("stall_rvalid", 32'(rvalid), 32'd1);
        check("stall_rdata0", rdata, 32'h5A);
        araddr = 5'h04;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("stall%0d_arready", i), 32'(arready), 32'd0);
            check($sformatf("stall%0d_rdata", i), rdata, 32'h5A);
        end
        rready = 1'b1;
        step();
        check("stall_rvalid_clr", 32'(rvalid), 32'd0);
        check("stall_arready_back", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        check("second_rvalid", 32'(rvalid), 32'd1);
        check("second_rdata", rdata, 32'h2);
        step();
        check("second_rvalid_clr", 32'(rvalid), 32'd0);

        // Reset during a pending write response
        gpio_i = 32'h0;
        bready = 1'b0;
        awaddr = 5'h0C; wdata = 32'h0000_00FF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_bvalid", 32'(bvalid), 32'd0);
        check("midrst_gpio_o", gpio_o, 32'd0);
        check("midrst_gpio_oe", gpio_oe, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_awready", 32'(awready), 32'd0);
        step();
        rst = 1'b0;
        bready = 1'b1;
        step();
        axi_read(5'h0C, data, resp);
        check("postrst_scratch", data, 32'h0);
        axi_read(5'h08, data, resp);
        check("postrst_mask", data, 32'h0);
        axi_write(5'h0C, 32'h0000_1234, 4'hF, resp);
        check("postrst_bresp", 32'(resp), 32'd0);
        axi_read(5'h0C, data, resp);
        check("postrst_scratch_wr", data, 32'h0000_1234);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
